// File: rtl/approx_error_monitor.sv
// Error-statistics monitor for an approximate multiplier: it feeds operand pairs to the external
// multiplier (full sweep or streamed) and accumulates ED/error statistics through a 3-stage pipeline.
module approx_error_monitor #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [N-1:0]   op_a,
  output logic [N-1:0]   op_b,
  input  logic [2*N-1:0] approx_p,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   num_tests,
  output logic [2*N:0]   err_count,
  output logic [4*N-1:0] sum_ed,
  output logic [4*N:0]   sum_err,
  output logic [2*N-1:0] max_ed
);
  localparam int PW = 2 * N;
  localparam logic [PW-1:0] K_ONE = 1;
  localparam logic [PW:0]   T_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic          mode_reg;
  logic [PW-1:0] k_reg;
  logic          drain_cnt_reg;
  logic          capture, last_pair;

  logic          v1_reg, v2_reg;
  logic [PW-1:0] approx1_reg, exact1_reg, exact_c;
  logic [PW:0]   err_c, err_neg, err2_reg;
  logic [PW-1:0] ed_c, ed2_reg;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    last_pair  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    if (state_reg == RUN) begin
      if (mode_reg) begin
        op_a      = in_a;
        op_b      = in_b;
        capture   = in_valid;
        last_pair = in_valid && in_last;
      end else begin
        op_a      = k_reg[PW-1:N];
        op_b      = k_reg[N-1:0];
        capture   = 1'b1;
        last_pair = (k_reg == '1);
      end
    end
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_pair) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      k_reg         <= '0;
      drain_cnt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;
      if (state_reg == IDLE && start) begin
        mode_reg <= mode;
        k_reg    <= '0;
      end else if (state_reg == RUN && !mode_reg && !last_pair) begin
        // Holds at all-ones on the final pair so the sweep never wraps.
        k_reg <= k_reg + K_ONE;
      end
    end
  end

  assign exact_c = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
  assign err_c   = {1'b0, approx1_reg} - {1'b0, exact1_reg};
  assign err_neg = -err_c;
  assign ed_c    = err_c[PW] ? err_neg[PW-1:0] : err_c[PW-1:0];

  // Only the valid bits need reset; data registers are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      v1_reg <= capture;
      v2_reg <= v1_reg;
    end
    approx1_reg <= approx_p;
    exact1_reg  <= exact_c;
    err2_reg    <= err_c;
    ed2_reg     <= ed_c;
  end

  always_ff @(posedge clk) begin
    if (rst || (state_reg == IDLE && start)) begin
      num_tests <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      sum_err   <= '0;
      max_ed    <= '0;
    end else if (v2_reg) begin
      num_tests <= num_tests + T_ONE;
      err_count <= err_count + {{PW{1'b0}}, (ed2_reg != '0)};
      sum_ed    <= sum_ed + {{PW{1'b0}}, ed2_reg};
      sum_err   <= sum_err + {{PW{err2_reg[PW]}}, err2_reg};
      max_ed    <= (ed2_reg > max_ed) ? ed2_reg : max_ed;
    end
  end

  assign busy = (state_reg == RUN) || (state_reg == DRAIN);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench: three monitor instances (N=2,4,8) driven with sweeps and random streams;
// expected statistics come from a plain-arithmetic model over the list of pairs issued.
module tb_approx_error_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint num;
    longint errc;
    longint sed;
    longint serr;
    longint maxed;
    longint dcyc;
  } exp_t;

  exp_t q2[$], q4[$], q8[$];
  exp_t zexp, rexp2, rexp4, rexp8, last4, e;
  int req2 = 0, ack2 = 0, req4 = 0, ack4 = 0, req8 = 0, ack8 = 0;
  int pa[$], pb[$];

  // N=2 instance
  logic rst2, start2, mode2, iv2, il2, busy2, done2;
  logic [1:0] ia2, ib2, oa2, ob2;
  logic [3:0] ap2, mx2;
  logic [4:0] nt2, ec2;
  logic [7:0] se2;
  logic [8:0] sr2;
  int sel2;
  // N=4 instance
  logic rst4, start4, mode4, iv4, il4, busy4, done4;
  logic [3:0] ia4, ib4, oa4, ob4;
  logic [7:0] ap4, mx4;
  logic [8:0] nt4, ec4;
  logic [15:0] se4;
  logic [16:0] sr4;
  int sel4;
  // N=8 instance
  logic rst8, start8, mode8, iv8, il8, busy8, done8;
  logic [7:0] ia8, ib8, oa8, ob8;
  logic [15:0] ap8, mx8;
  logic [16:0] nt8, ec8;
  logic [31:0] se8;
  logic [32:0] sr8;
  int sel8;

  approx_error_monitor #(.N(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .mode(mode2), .in_valid(iv2), .in_last(il2),
    .in_a(ia2), .in_b(ib2), .op_a(oa2), .op_b(ob2), .approx_p(ap2), .busy(busy2), .done(done2),
    .num_tests(nt2), .err_count(ec2), .sum_ed(se2), .sum_err(sr2), .max_ed(mx2));
  approx_error_monitor #(.N(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .in_valid(iv4), .in_last(il4),
    .in_a(ia4), .in_b(ib4), .op_a(oa4), .op_b(ob4), .approx_p(ap4), .busy(busy4), .done(done4),
    .num_tests(nt4), .err_count(ec4), .sum_ed(se4), .sum_err(sr4), .max_ed(mx4));
  approx_error_monitor #(.N(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .in_valid(iv8), .in_last(il8),
    .in_a(ia8), .in_b(ib8), .op_a(oa8), .op_b(ob8), .approx_p(ap8), .busy(busy8), .done(done8),
    .num_tests(nt8), .err_count(ec8), .sum_ed(se8), .sum_err(sr8), .max_ed(mx8));

  // External approximate multipliers, selectable per instance.
  function automatic int ax(int n, int sel, int a, int b);
    int p = a * b;
    int mask = (1 << (2 * n)) - 1;
    case (sel)
      1: return p & ~1;
      2: return (p ^ (a & b & 3)) & mask;
      3: return (a == 3 && b == 3) ? 8 : ((a == 2 && b == 2) ? 6 : p);
      4: return (p ^ ((a ^ b) & 31)) & mask;
      default: return p;
    endcase
  endfunction

  always_comb ap2 = 4'(ax(2, sel2, int'(oa2), int'(ob2)));
  always_comb ap4 = 8'(ax(4, sel4, int'(oa4), int'(ob4)));
  always_comb ap8 = 16'(ax(8, sel8, int'(oa8), int'(ob8)));

  function automatic exp_t model(int n, int sel, longint dcyc);
    exp_t r;
    r.num = 0; r.errc = 0; r.sed = 0; r.serr = 0; r.maxed = 0; r.dcyc = dcyc;
    foreach (pa[i]) begin
      int d = ax(n, sel, pa[i], pb[i]) - pa[i] * pb[i];
      int ad = (d < 0) ? -d : d;
      r.num++;
      if (d != 0) r.errc++;
      r.sed += ad;
      r.serr += d;
      if (ad > r.maxed) r.maxed = ad;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_stats(input string tag, input exp_t x, input longint nt, input longint ec,
                           input longint se, input longint sr, input longint mx);
    chk({tag, " num_tests"}, nt, x.num);
    chk({tag, " err_count"}, ec, x.errc);
    chk({tag, " sum_ed"}, se, x.sed);
    chk({tag, " sum_err"}, sr, x.serr);
    chk({tag, " max_ed"}, mx, x.maxed);
  endtask

  task automatic chk_idle(input string tag, input longint bz, input longint dn, input longint oa,
                          input longint ob);
    chk({tag, " busy"}, bz, 0);
    chk({tag, " done"}, dn, 0);
    chk({tag, " op_a"}, oa, 0);
    chk({tag, " op_b"}, ob, 0);
  endtask

  // Monitor: pops an expectation on each done pulse, flags overdue runs, serves idle checks.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("n2 unexpected done", 1, 0);
      else begin
        e = q2.pop_front();
        $display("n2 run done @%0d: tests=%0d errs=%0d sum_ed=%0d sum_err=%0d max_ed=%0d",
                 cyc, nt2, ec2, se2, $signed(sr2), mx2);
        chk_stats("n2", e, nt2, ec2, se2, $signed(sr2), mx2);
        chk("n2 done_cycle", cyc, e.dcyc);
      end
    end
    if (done4) begin
      if (q4.size() == 0) chk("n4 unexpected done", 1, 0);
      else begin
        e = q4.pop_front();
        $display("n4 run done @%0d: tests=%0d errs=%0d sum_ed=%0d sum_err=%0d max_ed=%0d",
                 cyc, nt4, ec4, se4, $signed(sr4), mx4);
        chk_stats("n4", e, nt4, ec4, se4, $signed(sr4), mx4);
        chk("n4 done_cycle", cyc, e.dcyc);
      end
    end
    if (done8) begin
      if (q8.size() == 0) chk("n8 unexpected done", 1, 0);
      else begin
        e = q8.pop_front();
        $display("n8 run done @%0d: tests=%0d errs=%0d sum_ed=%0d sum_err=%0d max_ed=%0d",
                 cyc, nt8, ec8, se8, $signed(sr8), mx8);
        chk_stats("n8", e, nt8, ec8, se8, $signed(sr8), mx8);
        chk("n8 done_cycle", cyc, e.dcyc);
      end
    end
    if (q2.size() != 0 && q2[0].dcyc < cyc) begin
      chk("n2 done timeout", cyc, q2[0].dcyc);
      void'(q2.pop_front());
    end
    if (q4.size() != 0 && q4[0].dcyc < cyc) begin
      chk("n4 done timeout", cyc, q4[0].dcyc);
      void'(q4.pop_front());
    end
    if (q8.size() != 0 && q8[0].dcyc < cyc) begin
      chk("n8 done timeout", cyc, q8[0].dcyc);
      void'(q8.pop_front());
    end
    if (req2 != ack2) begin
      $display("n2 idle check @%0d", cyc);
      chk_idle("n2 idle", busy2, done2, oa2, ob2);
      chk_stats("n2 idle", rexp2, nt2, ec2, se2, $signed(sr2), mx2);
      ack2 = req2;
    end
    if (req4 != ack4) begin
      $display("n4 idle check @%0d", cyc);
      chk_idle("n4 idle", busy4, done4, oa4, ob4);
      chk_stats("n4 idle", rexp4, nt4, ec4, se4, $signed(sr4), mx4);
      ack4 = req4;
    end
    if (req8 != ack8) begin
      $display("n8 idle check @%0d", cyc);
      chk_idle("n8 idle", busy8, done8, oa8, ob8);
      chk_stats("n8 idle", rexp8, nt8, ec8, se8, $signed(sr8), mx8);
      ack8 = req8;
    end
  end

  task automatic fill_sweep(input int n);
    pa.delete();
    pb.delete();
    for (int a = 0; a < (1 << n); a++)
      for (int b = 0; b < (1 << n); b++) begin
        pa.push_back(a);
        pb.push_back(b);
      end
  endtask

  task automatic wait_all(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q2.size() == 0 && q4.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep2(input int sel);
    sel2 = sel;
    fill_sweep(2);
    q2.push_back(model(2, sel, cyc + 1 + 16 + 2));
    start2 = 1'b1;
    mode2  = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    // Mode and stream inputs wiggle mid-sweep and must be ignored.
    mode2 = 1'b1;
    iv2 = 1'b1;
    il2 = 1'b1;
    repeat (3) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    iv2 = 1'b0;
    il2 = 1'b0;
    mode2 = 1'b0;
    wait_all(100);
  endtask

  localparam int NP = 12;
  logic [3:0] ra[NP], rb[NP];

  task automatic stream4(input bit gapped);
    pa.delete();
    pb.delete();
    for (int i = 0; i < NP; i++) begin
      pa.push_back(int'(ra[i]));
      pb.push_back(int'(rb[i]));
    end
    start4 = 1'b1;
    mode4  = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (gapped) begin
        int g = (i == 4) ? 2 : int'($urandom_range(0, 2));
        repeat (g) begin
          iv4 = 1'b0;
          il4 = 1'($urandom_range(0, 1));
          ia4 = 4'($urandom);
          ib4 = 4'($urandom);
          if (i == 4) begin
            start4 = 1'b1;
            mode4  = 1'b0;
          end
          @(negedge clk);
          start4 = 1'b0;
        end
      end
      iv4 = 1'b1;
      ia4 = ra[i];
      ib4 = rb[i];
      il4 = (i == NP - 1);
      if (il4) q4.push_back(model(4, 2, cyc + 3));
      @(negedge clk);
    end
    iv4 = 1'b0;
    il4 = 1'b0;
    wait_all(100);
  endtask

  initial begin
    {rst2, rst4, rst8} = 3'b111;
    {start2, start4, start8} = 3'b000;
    {mode2, mode4, mode8} = 3'b000;
    {iv2, iv4, iv8, il2, il4, il8} = 6'b0;
    ia2 = '0; ib2 = '0; ia4 = '0; ib4 = '0; ia8 = '0; ib8 = '0;
    sel2 = 0; sel4 = 0; sel8 = 0;
    zexp.num = 0; zexp.errc = 0; zexp.sed = 0; zexp.serr = 0; zexp.maxed = 0; zexp.dcyc = 0;
    repeat (3) @(negedge clk);
    {rst2, rst4, rst8} = 3'b000;
    rexp2 = zexp; rexp4 = zexp; rexp8 = zexp;
    req2++; req4++; req8++;
    repeat (2) @(negedge clk);

    // N=2 sweeps: exact multiplier, then bit0 cleared.
    sweep2(0);
    sweep2(1);

    // Reset while k=7 is presented, then a fresh clean sweep.
    sel2 = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (7) @(negedge clk);
    rst2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    start2 = 1'b0;
    rexp2 = zexp;
    req2++;
    repeat (4) @(negedge clk);
    req2++;
    repeat (2) @(negedge clk);
    sweep2(0);

    // N=4 two-pair stream.
    sel4 = 3;
    pa.delete(); pb.delete();
    pa.push_back(3); pb.push_back(3);
    pa.push_back(2); pb.push_back(2);
    start4 = 1'b1;
    mode4  = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    iv4 = 1'b1; ia4 = 4'd3; ib4 = 4'd3;
    @(negedge clk);
    ia4 = 4'd2; ib4 = 4'd2; il4 = 1'b1;
    last4 = model(4, 3, cyc + 3);
    q4.push_back(last4);
    @(negedge clk);
    iv4 = 1'b0; il4 = 1'b0;
    wait_all(50);

    // Stream activity while idle must leave the results untouched.
    repeat (5) begin
      iv4 = 1'b1;
      il4 = 1'($urandom_range(0, 1));
      ia4 = 4'($urandom);
      ib4 = 4'($urandom);
      @(negedge clk);
    end
    iv4 = 1'b0; il4 = 1'b0;
    rexp4 = last4;
    req4++;
    repeat (2) @(negedge clk);

    // Random stream: gapped with a stray start and mode flip, then the same pairs ungapped.
    sel4 = 2;
    for (int i = 0; i < NP; i++) begin
      ra[i] = 4'($urandom);
      rb[i] = 4'($urandom);
    end
    stream4(1'b1);
    stream4(1'b0);

    // N=8 exhaustive sweep.
    sel8 = 4;
    fill_sweep(8);
    q8.push_back(model(8, 4, cyc + 1 + 65536 + 2));
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_all(70000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
